// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares one as4c4m16sa SDRAM controller between NUM_PORTS requesters. The
// arbiter runs one single-word read or write at a time and picks requesters
// round-robin. It presents the chosen operation on command/data_address/
// data_write and holds it until the controller reports completion. It then
// returns the result to the requester and drops the command for one cycle
// before it accepts the next request.
//
// Ports
//   clk              single clock, shared with the controller
//   reset_n          asynchronous active-low reset
//   req_valid        per-port request pending
//   req_write        per-port op type (1 = write, 0 = read)
//   req_address      per-port word address, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data         per-port write data,   slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready        1-cycle pulse: request of port i accepted (combinational)
//   resp_valid       1-cycle pulse: read data for port i present on resp_data
//   resp_data        read data, meaningful only with a resp_valid bit
//   write_ack        1-cycle pulse: write of port i completed
//   timeout          1-cycle pulse: op of port i aborted by the watchdog
//   command          to controller: 0 idle, 1 write, 2 read
//   data_address     to controller: word address
//   data_write       to controller: write data
//   data_read        from controller: read word
//   data_read_valid  from controller: read word valid
//   data_write_done  from controller: write finished
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_WIDTH     = 22,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_PORTS-1:0]             req_valid,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_PORTS-1:0]             req_ready,
   output logic [NUM_PORTS-1:0]             resp_valid,
   output logic [DATA_WIDTH-1:0]            resp_data,
   output logic [NUM_PORTS-1:0]             write_ack,
   output logic [NUM_PORTS-1:0]             timeout,
   output logic [1:0]                       command,
   output logic [ADDR_WIDTH-1:0]            data_address,
   output logic [DATA_WIDTH-1:0]            data_write,
   input  logic [DATA_WIDTH-1:0]            data_read,
   input  logic                             data_read_valid,
   input  logic                             data_write_done
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   // Watchdog counts 0 .. TIMEOUT_CYCLES-1; reaching the last value without
   // completion means TIMEOUT_CYCLES ISSUE cycles have elapsed.
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST =
      WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit WD_ENABLE = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [PTR_W-1:0]        ptr_reg, ptr_next;
   logic [PTR_W-1:0]        port_reg, port_next;
   logic                    op_write_reg, op_write_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic [DATA_WIDTH-1:0]   data_reg, data_next;
   logic [1:0]              command_reg, command_next;
   logic [WD_W-1:0]         wd_reg, wd_next;
   logic [NUM_PORTS-1:0]    resp_valid_reg, resp_valid_next;
   logic [NUM_PORTS-1:0]    write_ack_reg, write_ack_next;
   logic [NUM_PORTS-1:0]    timeout_reg, timeout_next;
   logic [DATA_WIDTH-1:0]   resp_data_reg, resp_data_next;

   logic [ADDR_WIDTH-1:0]   port_addr [NUM_PORTS];
   logic [DATA_WIDTH-1:0]   port_data [NUM_PORTS];
   logic                    grant_found;
   logic [PTR_W-1:0]        grant_idx;
   logic [NUM_PORTS-1:0]    grant_onehot;
   logic [NUM_PORTS-1:0]    port_onehot;
   logic                    complete;
   logic                    wd_expired;

   // Unpack the flat per-port buses and build one-hot decodes.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign port_addr[gi]    = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign port_data[gi]    = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
         assign grant_onehot[gi] = (grant_idx == PTR_W'(gi));
         assign port_onehot[gi]  = (port_reg == PTR_W'(gi));
      end
   endgenerate

   // Round-robin search: first pending port at or above the pointer, wrapping.
   always_comb begin
      int               scan_idx;
      logic [PTR_W-1:0] scan_ptr;
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      scan_ptr    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         scan_idx = int'(ptr_reg) + k;
         if (scan_idx >= NUM_PORTS) begin
            scan_idx = scan_idx - NUM_PORTS;
         end
         scan_ptr = PTR_W'(scan_idx);
         if (!grant_found && req_valid[scan_ptr]) begin
            grant_found = 1'b1;
            grant_idx   = scan_ptr;
         end
      end
   end

   // Acceptance is combinational so the requester sees it in the grant cycle.
   // It is masked by reset_n because the FSM is forced to IDLE during reset
   // while requests may still be pending.
   assign req_ready = (state_reg == ST_IDLE && grant_found && reset_n) ?
                      grant_onehot : '0;

   always_comb begin
      state_next      = state_reg;
      ptr_next        = ptr_reg;
      port_next       = port_reg;
      op_write_next   = op_write_reg;
      addr_next       = addr_reg;
      data_next       = data_reg;
      command_next    = command_reg;
      wd_next         = wd_reg;
      resp_valid_next = '0;
      write_ack_next  = '0;
      timeout_next    = '0;
      resp_data_next  = resp_data_reg;
      complete        = 1'b0;
      wd_expired      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (grant_found) begin
               state_next    = ST_ISSUE;
               ptr_next      = (grant_idx == PTR_W'(NUM_PORTS - 1)) ?
                               '0 : grant_idx + PTR_W'(1);
               port_next     = grant_idx;
               op_write_next = req_write[grant_idx];
               addr_next     = port_addr[grant_idx];
               data_next     = port_data[grant_idx];
               command_next  = req_write[grant_idx] ? CMD_WRITE : CMD_READ;
               wd_next       = '0;
            end
         end

         ST_ISSUE: begin
            // Only the strobe matching the op in flight counts.
            complete   = op_write_reg ? data_write_done : data_read_valid;
            wd_expired = WD_ENABLE && (wd_reg == WD_LAST);
            if (complete) begin
               state_next   = ST_RECOVER;
               command_next = CMD_IDLE;
               if (op_write_reg) begin
                  write_ack_next = port_onehot;
               end else begin
                  resp_valid_next = port_onehot;
                  resp_data_next  = data_read;
               end
            end else if (wd_expired) begin
               state_next   = ST_RECOVER;
               command_next = CMD_IDLE;
               timeout_next = port_onehot;
            end else if (WD_ENABLE) begin
               wd_next = wd_reg + WD_W'(1);
            end
         end

         // One idle command cycle so the controller cannot re-issue the op.
         ST_RECOVER: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next   = ST_IDLE;
            command_next = CMD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         ptr_reg        <= '0;
         port_reg       <= '0;
         op_write_reg   <= 1'b0;
         addr_reg       <= '0;
         data_reg       <= '0;
         command_reg    <= CMD_IDLE;
         wd_reg         <= '0;
         resp_valid_reg <= '0;
         write_ack_reg  <= '0;
         timeout_reg    <= '0;
         resp_data_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         ptr_reg        <= ptr_next;
         port_reg       <= port_next;
         op_write_reg   <= op_write_next;
         addr_reg       <= addr_next;
         data_reg       <= data_next;
         command_reg    <= command_next;
         wd_reg         <= wd_next;
         resp_valid_reg <= resp_valid_next;
         write_ack_reg  <= write_ack_next;
         timeout_reg    <= timeout_next;
         resp_data_reg  <= resp_data_next;
      end
   end

   assign command      = command_reg;
   assign data_address = addr_reg;
   assign data_write   = data_reg;
   assign resp_valid   = resp_valid_reg;
   assign write_ack    = write_ack_reg;
   assign timeout      = timeout_reg;
   assign resp_data    = resp_data_reg;

endmodule
